// File: rtl/norm_sequencer.sv
// rtl/norm_sequencer.sv - post-add normalizer: shifts an adder sum left one bit per cycle
// until the hidden bit reaches [26], the sum is zero, or the exponent bottoms out.
module norm_sequencer #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_sum,
  input  logic [EXP_W-1:0] in_exp,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_mant,
  output logic [2:0]       out_grs,
  output logic [EXP_W-1:0] out_exp,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_uflow,
  output logic [4:0]       out_shift
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           state_q, state_d;
  logic [26:0]      sum_q, sum_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic             sign_q, sign_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [23:0]      out_mant_q, out_mant_d;
  logic [2:0]       out_grs_q, out_grs_d;
  logic [EXP_W-1:0] out_exp_q, out_exp_d;
  logic             out_sign_q, out_sign_d;
  logic             out_zero_q, out_zero_d;
  logic             out_uflow_q, out_uflow_d;
  logic [4:0]       out_shift_q, out_shift_d;

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_mant_d  = out_mant_q;
    out_grs_d   = out_grs_q;
    out_exp_d   = out_exp_q;
    out_sign_d  = out_sign_q;
    out_zero_d  = out_zero_q;
    out_uflow_d = out_uflow_q;
    out_shift_d = out_shift_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sum_d   = in_sum;
          exp_d   = in_exp;
          sign_d  = in_sign;
          cnt_d   = 5'd0;
          state_d = NORM;
        end
      end
      NORM: begin
        // Priority: already normalized, then zero, then exponent floor, else shift.
        if (sum_q[26] || (sum_q == 27'd0) || (exp_q <= EXP_W'(1))) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sign_d  = sign_q;
          out_mant_d  = sum_q[26:3];
          out_grs_d   = sum_q[2:0];
          out_exp_d   = exp_q;
          out_shift_d = cnt_q;
          out_zero_d  = 1'b0;
          out_uflow_d = 1'b0;
          if (!sum_q[26] && (sum_q == 27'd0)) begin
            out_exp_d   = '0;
            out_shift_d = 5'd0;
            out_zero_d  = 1'b1;
          end else if (!sum_q[26]) begin
            out_uflow_d = 1'b1;
          end
        end else begin
          sum_d = {sum_q[25:0], 1'b0};
          exp_d = exp_q - EXP_W'(1);
          cnt_d = cnt_q + 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_mant_q  <= '0;
      out_grs_q   <= '0;
      out_exp_q   <= '0;
      out_sign_q  <= 1'b0;
      out_zero_q  <= 1'b0;
      out_uflow_q <= 1'b0;
      out_shift_q <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_mant_q  <= out_mant_d;
      out_grs_q   <= out_grs_d;
      out_exp_q   <= out_exp_d;
      out_sign_q  <= out_sign_d;
      out_zero_q  <= out_zero_d;
      out_uflow_q <= out_uflow_d;
      out_shift_q <= out_shift_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mant  = out_mant_q;
  assign out_grs   = out_grs_q;
  assign out_exp   = out_exp_q;
  assign out_sign  = out_sign_q;
  assign out_zero  = out_zero_q;
  assign out_uflow = out_uflow_q;
  assign out_shift = out_shift_q;

endmodule

// File: tb/tb_norm_sequencer.sv
// tb/tb_norm_sequencer.sv - scoreboard bench for norm_sequencer
`timescale 1ns/1ps
module tb_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_sum = '0;
  logic [7:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_mant;
  logic [2:0]  out_grs;
  logic [7:0]  out_exp;
  logic        out_sign, out_zero, out_uflow;
  logic [4:0]  out_shift;

  norm_sequencer #(.EXP_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_grs(out_grs), .out_exp(out_exp),
    .out_sign(out_sign), .out_zero(out_zero), .out_uflow(out_uflow),
    .out_shift(out_shift)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges++;

  typedef struct packed {
    logic [23:0] mant;
    logic [2:0]  grs;
    logic [7:0]  exp;
    logic        sign;
    logic        zero;
    logic        uflow;
    logic [4:0]  shift;
  } result_t;

  typedef struct {
    result_t r;
    int      lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   t_xfer = 0;

  function automatic result_t observe();
    result_t r;
    r.mant = out_mant; r.grs = out_grs; r.exp = out_exp; r.sign = out_sign;
    r.zero = out_zero; r.uflow = out_uflow; r.shift = out_shift;
    return r;
  endfunction

  // Reference: leading-zero count limited by the shifts the exponent can absorb.
  function automatic exp_t model(logic [26:0] s, logic [7:0] e, logic sg);
    exp_t        x;
    int          k, avail, sh;
    logic [26:0] v;
    x.r = '0;
    x.r.sign = sg;
    if (s == 27'd0) begin
      x.r.zero = 1'b1;
      x.lat = 1;
      return x;
    end
    k = 0;
    for (int i = 26; i >= 0; i--) begin
      if (s[i]) break;
      k++;
    end
    avail = (e > 8'd1) ? int'(e) - 1 : 0;
    sh = (k <= avail) ? k : avail;
    x.r.uflow = (k > avail);
    v = s << sh;
    x.r.mant  = v[26:3];
    x.r.grs   = v[2:0];
    x.r.exp   = 8'(int'(e) - sh);
    x.r.shift = 5'(sh);
    x.lat = 1 + sh;
    return x;
  endfunction

  task automatic drive_op(input logic [26:0] s, input logic [7:0] e, input logic sg,
                          input bit push, input exp_t ex, output bit ok);
    int w = 0;
    ok = 1'b1;
    if (push) sb.push_back(ex);
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin ok = 1'b0; return; end
    in_valid = 1'b1; in_sum = s; in_exp = e; in_sign = sg;
    @(posedge clk); #1;
    t_xfer = edges;
    in_valid = 1'b0; in_sum = 27'($urandom); in_exp = 8'($urandom);
  endtask

  task automatic collect(output result_t r, output int lat, output bit ok);
    int w = 0;
    while (!out_valid && w < 60) begin @(posedge clk); #1; w++; end
    ok = out_valid;
    lat = edges - t_xfer;
    r = observe();
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, observe()} !== '0)
      begin n_err++; $display("FAIL reset_async: got %h expected 0", {in_ready, out_valid, observe()}); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({in_ready, out_valid, observe()} !== '0)
      begin n_err++; $display("FAIL reset_held: got %h expected 0", {in_ready, out_valid, observe()}); end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_release_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_first_edge_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_vectors();
    logic [26:0] vs[4]  = '{27'h4000000, 27'h0000008, 27'h0000000, 27'h0000100};
    logic [7:0]  ve[4]  = '{8'd100, 8'd100, 8'd50, 8'd5};
    logic        vsg[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_t        ex[4];
    result_t     r;
    exp_t        e;
    int          lat;
    bit          ok, ok2;
    ex[0].r = {24'h800000, 3'd0, 8'd100, 1'b1, 1'b0, 1'b0, 5'd0};  ex[0].lat = 1;
    ex[1].r = {24'h800000, 3'd0, 8'd77,  1'b0, 1'b0, 1'b0, 5'd23}; ex[1].lat = 24;
    ex[2].r = {24'h000000, 3'd0, 8'd0,   1'b0, 1'b1, 1'b0, 5'd0};  ex[2].lat = 1;
    ex[3].r = {24'h000200, 3'd0, 8'd1,   1'b1, 1'b0, 1'b1, 5'd4};  ex[3].lat = 5;
    for (int i = 0; i < 4; i++) begin
      drive_op(vs[i], ve[i], vsg[i], 1'b1, ex[i], ok);
      collect(r, lat, ok2);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || !ok2 || r !== e.r)
        begin n_err++; $display("FAIL vector%0d_result: got %h expected %h", i, r, e.r); end
      n_cmp++;
      if (lat !== e.lat)
        begin n_err++; $display("FAIL vector%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [26:0] s;
    logic [7:0]  ev;
    logic        sg;
    result_t     r;
    exp_t        e;
    int          lat;
    bit          ok, ok2;
    for (int i = 0; i < 12; i++) begin
      s  = 27'($urandom) >> $urandom_range(0, 26);
      ev = (i % 3 == 0) ? 8'($urandom_range(0, 12)) : 8'($urandom);
      sg = 1'($urandom);
      drive_op(s, ev, sg, 1'b1, model(s, ev, sg), ok);
      collect(r, lat, ok2);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || !ok2 || r !== e.r)
        begin n_err++; $display("FAIL random%0d_result: sum %h exp %0d got %h expected %h", i, s, ev, r, e.r); end
      n_cmp++;
      if (lat !== e.lat)
        begin n_err++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, e.lat); end
      release_out();
    end
  endtask

  task automatic test_hold();
    result_t r, snap;
    exp_t    e;
    int      lat;
    bit      ok, ok2;
    drive_op(27'h0040000, 8'd60, 1'b1, 1'b1, model(27'h0040000, 8'd60, 1'b1), ok);
    collect(r, lat, ok2);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || !ok2 || r !== e.r)
      begin n_err++; $display("FAIL hold_result: got %h expected %h", r, e.r); end
    snap = e.r;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_sum = 27'($urandom); in_exp = 8'($urandom); in_sign = 1'($urandom);
      @(posedge clk); #1;
      n_cmp++;
      if (observe() !== snap || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin n_err++; $display("FAIL hold_cycle%0d: got %h v%b r%b expected %h v1 r0", i, observe(), out_valid, in_ready, snap); end
    end
    in_valid = 1'b0;
    release_out();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_err++; $display("FAIL hold_release: got v%b r%b expected v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [26:0] s;
    logic [7:0]  ev;
    result_t     r;
    exp_t        e;
    int          lat;
    bit          ok, ok2;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = 27'h0001234 << (i * 5);
      ev = 8'(40 + i);
      drive_op(s, ev, 1'(i), 1'b1, model(s, ev, 1'(i)), ok);
      collect(r, lat, ok2);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || !ok2 || r !== e.r || lat !== e.lat)
        begin n_err++; $display("FAIL b2b%0d: got %h lat %0d expected %h lat %0d", i, r, lat, e.r, e.lat); end
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin n_err++; $display("FAIL b2b%0d_return: got v%b r%b expected v0 r1", i, out_valid, in_ready); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t dummy;
    bit   ok, seen;
    dummy.r = '0; dummy.lat = 0;
    drive_op(27'h0000001, 8'd100, 1'b1, 1'b0, dummy, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL reset_mid_transfer: got no transfer expected transfer"); end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, observe()} !== '0)
      begin n_err++; $display("FAIL reset_mid_async: got %h expected 0", {in_ready, out_valid, observe()}); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_ready: got %b expected 1", in_ready); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL reset_mid_discard: got out_valid 1 expected 0"); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/norm_sequencer.md
NORM_SEQUENCER -- requirements
Module: norm_sequencer

Interface
REQ-001 Parameter EXP_W, default 8: width of exponent ports.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 in_valid  input  1  upstream operand valid.
REQ-005 in_ready  output  1  block can accept an operand.
REQ-006 in_sum  input  27  unnormalized adder sum; bits [2:0] are guard/round/sticky.
REQ-007 in_exp  input  EXP_W  biased exponent of in_sum.
REQ-008 in_sign  input  1  sign of in_sum.
REQ-009 out_valid  output  1  normalized result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 out_mant  output  24  normalized mantissa, hidden bit at [23].
REQ-012 out_grs  output  3  guard/round/sticky bits below out_mant.
REQ-013 out_exp  output  EXP_W  adjusted exponent.
REQ-014 out_sign  output  1  in_sign passed through.
REQ-015 out_zero  output  1  result is exact zero.
REQ-016 out_uflow  output  1  shifting stopped at minimum exponent; result denormal.
REQ-017 out_shift  output  5  number of left shifts applied.

Function
REQ-018 FSM states: IDLE, NORM, DONE; operands are not overlapped, one in flight at most.
REQ-019 in_ready is registered and is 1 only in IDLE; transfer occurs when in_valid && in_ready.
REQ-020 On transfer: capture sum_reg=in_sum, exp_reg=in_exp, sign, shift count=0; enter NORM; in_ready drops the next cycle.
REQ-021 NORM, per cycle, in priority order: sum_reg[26]==1 -> terminate; sum_reg==0 -> terminate as zero; exp_reg<=1 -> terminate as underflow; else sum_reg<<=1 (zero fill), exp_reg-=1, shift count+=1, stay in NORM.
REQ-022 On terminate: register out_mant=sum_reg[26:3], out_grs=sum_reg[2:0], out_exp=exp_reg, out_shift=count, out_sign=sign; enter DONE with out_valid=1.
REQ-023 Zero terminate: out_mant=0, out_grs=0, out_exp=0, out_shift=0, out_zero=1, out_uflow=0.
REQ-024 Underflow terminate: out_uflow=1, out_exp=exp_reg (0 or 1), mantissa left partially normalized.
REQ-025 Normal terminate: out_zero=0, out_uflow=0.
REQ-026 Latency: transfer at cycle T, k leading zeros (no underflow) -> out_valid at T+2+k; zero input -> T+2; max T+28 (k=26).
REQ-027 DONE: out_valid held 1 and all out_* held stable until out_ready sampled 1; then out_valid=0, state IDLE, in_ready=1 same edge.
REQ-028 in_valid while not in IDLE is ignored; in_sum/in_exp changes outside transfer have no effect.
REQ-029 out_ready while not in DONE is ignored.

Reset
REQ-030 rst_n low forces immediately, regardless of state: state=IDLE, in_ready=0, out_valid=0, all other outputs and internal registers 0.
REQ-031 First rising clk edge after rst_n release sets in_ready=1; an in-flight operand at reset is discarded with no out_valid.

Verification
REQ-032 in_sum=27'h4000000, in_exp=100 -> out_mant=24'h800000, out_exp=100, out_shift=0, out_valid at T+2.
REQ-033 in_sum=27'h0000008, in_exp=100 -> out_mant=24'h800000, out_grs=0, out_exp=77, out_shift=23, out_valid at T+25.
REQ-034 in_sum=0, in_exp=50 -> out_zero=1, out_mant=0, out_exp=0, out_valid at T+2.
REQ-035 in_sum=27'h0000100, in_exp=5 -> out_uflow=1, out_exp=1, out_shift=4, out_mant=24'h000200, out_valid at T+6.
REQ-036 Result held with out_ready=0 for 5 cycles while in_valid pulses -> outputs stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge.
REQ-037 rst_n pulsed low mid-NORM (in_sum=27'h0000001) -> out_valid never asserts for that operand, all outputs 0 during reset, in_ready=1 one edge after release.
